uart_prog_loader: RTL

//  UART receiver and byte FIFO that streams a Brainfuck program from a host into cpu_core's load path.

---
 rtl/uart_prog_loader.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO. Once armed,
// received bytes (optionally restricted to Brainfuck opcodes) are streamed to
// the program-load consumer over a valid/ready interface. A terminator byte
// closes the transfer; prog_done pulses once the FIFO has drained.

module uart_prog_loader #(
   parameter int unsigned CLK_HZ     = 12000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [7:0]  TERM_BYTE  = 8'h00,
   parameter bit          FILTER     = 1'b1
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        arm,
   input  logic        uart_rx,
   output logic [7:0]  prog_data,
   output logic        prog_valid,
   input  logic        prog_ready,
   output logic        prog_done,
   output logic        loading,
   output logic        overflow,
   output logic        frame_err,
   output logic [15:0] byte_count
);

   localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] DIV_RELOAD  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO    = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ZERO    = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0] OCC_ONE     = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(FIFO_DEPTH);

   // True for the eight Brainfuck command characters.
   function automatic logic is_bf_opcode(input logic [7:0] b);
      logic hit;
      case (b)
         8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: hit = 1'b1;
         default:                                                hit = 1'b0;
      endcase
      return hit;
   endfunction

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_OFF, LD_ARMED, LD_DRAIN, LD_DONE} ld_state_t;

   logic             rx_meta_r;
   logic             rx_sync_r;
   rx_state_t        rx_state_r;
   logic [CNT_W-1:0] baud_cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic             rx_strobe_r;
   logic [7:0]       rx_byte_r;
   logic             frame_err_evt_r;

   ld_state_t        ld_state_r;
   logic             loading_r;
   logic             prog_done_r;
   logic             overflow_r;
   logic             frame_err_r;
   logic [15:0]      byte_count_r;

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] fifo_cnt_r;
   logic             fifo_valid_r;

   logic             pop_s;
   logic             push_req_s;
   logic             push_s;
   logic             drop_s;
   logic             term_s;
   logic             full_s;
   logic             arm_accept_s;
   logic [OCC_W-1:0] cnt_next_s;

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= uart_rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Receive FSM: mid-bit sampling, baud counter reloaded on every state entry.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rx_state_r      <= RX_IDLE;
         baud_cnt_r      <= CNT_ZERO;
         bit_idx_r       <= 3'd0;
         shift_r         <= 8'h00;
         rx_strobe_r     <= 1'b0;
         rx_byte_r       <= 8'h00;
         frame_err_evt_r <= 1'b0;
      end else begin
         rx_strobe_r     <= 1'b0;
         frame_err_evt_r <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               if (!rx_sync_r) begin
                  rx_state_r <= RX_START;
                  baud_cnt_r <= HALF_RELOAD;
               end
            end
            RX_START: begin
               if (baud_cnt_r == CNT_ZERO) begin
                  baud_cnt_r <= DIV_RELOAD;
                  if (!rx_sync_r) begin
                     rx_state_r <= RX_DATA;
                     bit_idx_r  <= 3'd0;
                  end else begin
                     // Start bit did not survive to mid-bit: treat as a glitch.
                     rx_state_r <= RX_IDLE;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r - CNT_ONE;
               end
            end
            RX_DATA: begin
               if (baud_cnt_r == CNT_ZERO) begin
                  baud_cnt_r <= DIV_RELOAD;
                  shift_r    <= {rx_sync_r, shift_r[7:1]};
                  if (bit_idx_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r - CNT_ONE;
               end
            end
            RX_STOP: begin
               if (baud_cnt_r == CNT_ZERO) begin
                  baud_cnt_r <= DIV_RELOAD;
                  rx_state_r <= RX_IDLE;
                  if (rx_sync_r) begin
                     rx_strobe_r <= 1'b1;
                     rx_byte_r   <= shift_r;
                  end else begin
                     frame_err_evt_r <= 1'b1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r - CNT_ONE;
               end
            end
            default: begin
               rx_state_r <= RX_IDLE;
               baud_cnt_r <= DIV_RELOAD;
            end
         endcase
      end
   end

   // Push/pop decisions for the FIFO and the next occupancy.
   always_comb begin
      pop_s        = fifo_valid_r & prog_ready;
      push_req_s   = 1'b0;
      term_s       = 1'b0;
      arm_accept_s = arm & ((ld_state_r == LD_OFF) || (ld_state_r == LD_DONE));
      if ((ld_state_r == LD_ARMED) && rx_strobe_r) begin
         if (rx_byte_r == TERM_BYTE) begin
            term_s = 1'b1;
         end else if ((FILTER == 1'b0) || is_bf_opcode(rx_byte_r)) begin
            push_req_s = 1'b1;
         end else begin
            push_req_s = 1'b0;
         end
      end else begin
         push_req_s = 1'b0;
      end
      full_s = (fifo_cnt_r == OCC_FULL);
      // A pop in the same cycle frees the slot the push needs.
      push_s = push_req_s & (~full_s | pop_s);
      drop_s = push_req_s & full_s & ~pop_s;
      if (arm_accept_s) begin
         cnt_next_s = OCC_ZERO;
      end else begin
         case ({push_s, pop_s})
            2'b10:   cnt_next_s = fifo_cnt_r + OCC_ONE;
            2'b01:   cnt_next_s = fifo_cnt_r - OCC_ONE;
            default: cnt_next_s = fifo_cnt_r;
         endcase
      end
   end

   // FIFO storage and pointers; arming flushes the queue.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r     <= PTR_ZERO;
         rd_ptr_r     <= PTR_ZERO;
         fifo_cnt_r   <= OCC_ZERO;
         fifo_valid_r <= 1'b0;
      end else begin
         fifo_cnt_r   <= cnt_next_s;
         fifo_valid_r <= (cnt_next_s != OCC_ZERO);
         if (arm_accept_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
         end else begin
            if (push_s) begin
               mem_r[wr_ptr_r] <= rx_byte_r;
               wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
         end
      end
   end

   // Loader FSM with its sticky status flags and delivered-byte counter.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         ld_state_r   <= LD_OFF;
         loading_r    <= 1'b0;
         prog_done_r  <= 1'b0;
         overflow_r   <= 1'b0;
         frame_err_r  <= 1'b0;
         byte_count_r <= 16'h0000;
      end else begin
         prog_done_r <= 1'b0;

         if (frame_err_evt_r) begin
            frame_err_r <= 1'b1;
         end else if (arm_accept_s) begin
            frame_err_r <= 1'b0;
         end

         if (arm_accept_s) begin
            overflow_r <= 1'b0;
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end

         if (arm_accept_s) begin
            byte_count_r <= 16'h0000;
         end else if (pop_s && (byte_count_r != 16'hFFFF)) begin
            byte_count_r <= byte_count_r + 16'h0001;
         end

         case (ld_state_r)
            LD_OFF, LD_DONE: begin
               if (arm) begin
                  ld_state_r <= LD_ARMED;
                  loading_r  <= 1'b1;
               end
            end
            LD_ARMED: begin
               if (term_s) begin
                  ld_state_r <= LD_DRAIN;
               end
            end
            LD_DRAIN: begin
               if (!fifo_valid_r) begin
                  ld_state_r  <= LD_DONE;
                  loading_r   <= 1'b0;
                  prog_done_r <= 1'b1;
               end
            end
            default: begin
               ld_state_r <= LD_OFF;
               loading_r  <= 1'b0;
            end
         endcase
      end
   end

   assign prog_data  = mem_r[rd_ptr_r];
   assign prog_valid = fifo_valid_r;
   assign prog_done  = prog_done_r;
   assign loading    = loading_r;
   assign overflow   = overflow_r;
   assign frame_err  = frame_err_r;
   assign byte_count = byte_count_r;

endmodule
